alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one combinational alu instance between two requesters (e.g. execute stage and a
//  branch/address helper unit). Round-robin arbitration, valid/ready on request and response,
//  operands registered before the alu, result registered after it. Drives the alu SrcA/SrcB/
//  Operation inputs and samples ALUResult. One operation in flight; 3-cycle best-case turnaround.
// PARAMETERS
//  DATA_WIDTH     32  operand/result width, equal to the alu DATA_WIDTH
//  OPCODE_LENGTH  4   alu operation code width, equal to the alu OPCODE_LENGTH
// PORTS
//  clk          in   1              single clock, rising edge
//  reset        in   1              synchronous, active-high
//  req0_valid   in   1              requester 0 has an operation
//  req0_ready   out  1              arbiter accepts requester 0 this cycle
//  req0_a       in   DATA_WIDTH     requester 0 operand A
//  req0_b       in   DATA_WIDTH     requester 0 operand B
//  req0_op      in   OPCODE_LENGTH  requester 0 alu operation code
//  req1_*       same set as req0_*  requester 1
//  rsp0_valid   out  1              result for requester 0 available
//  rsp0_ready   in   1              requester 0 takes result
//  rsp0_result  out  DATA_WIDTH     result for requester 0
//  rsp1_*       same set as rsp0_*  requester 1
//  alu_srca     out  DATA_WIDTH     to alu SrcA
//  alu_srcb     out  DATA_WIDTH     to alu SrcB
//  alu_op       out  OPCODE_LENGTH  to alu Operation
//  alu_result   in   DATA_WIDTH     from alu ALUResult (combinational)
//  busy         out  1              high whenever state != IDLE
// BEHAVIOUR
//  - Reset: state IDLE, all outputs 0, operand/result/owner regs 0, last_grant=1 (req0 wins first).
//  - FSM IDLE -> EXEC -> RESP -> IDLE. No other states.
//  - IDLE: grant = only valid requester; if both valid, the one != last_grant. reqN_ready =
//    (state==IDLE) && grant==N (combinational, depends on reqN_valid). On valid&&ready: latch
//    a/b/op into operand regs, owner<=N, last_grant<=N, go EXEC. No valid: stay IDLE.
//  - EXEC (one cycle): alu ports show operand regs; at clock edge result_reg<=alu_result, go RESP.
//  - RESP: rsp<owner>_valid=1, rsp<owner>_result=result_reg; other rsp valid=0. Hold valid and
//    result stable until rsp<owner>_ready=1; on that edge go IDLE. Other requester's rsp_ready ignored.
//  - alu_srca/srcb/op always equal operand regs (hold last op outside EXEC; 0 after reset).
//  - Both req_ready low in EXEC and RESP; no accept in the cycle RESP completes.
//  - Latency: accept at edge ending cycle N -> rsp_valid from cycle N+2; next accept earliest N+3.
//  - Opcodes not decoded; any value forwarded to alu unchanged (undefined codes yield 0 there).
//  - Requesters hold valid and payload until accepted; arbiter never drops a held request.
//  - Reset mid-operation (EXEC or RESP): in-flight op discarded, no response issued, full reset state.
//  - Fairness: with both valid continuously, grants strictly alternate 0,1,0,1...
// TESTING
//  - After reset, req0 ADD(0010) a=5 b=7 -> req0_ready=1 same cycle; rsp0_valid 2 cycles later, rsp0_result=12.
//  - req0 and req1 valid together, req1 XOR a=0xF0 b=0xFF -> req0 served first; then req1, rsp1_result=0x0F.
//  - Both valid continuously for 6 ops -> grant order 0,1,0,1,0,1; no rsp to wrong owner.
//  - rsp0_ready=0 for 4 cycles in RESP -> rsp0_valid held 1, result stable, both req_ready=0, busy=1.
//  - Equal op(1000) a=b=0xDEADBEEF -> result 1; a=1,b=2 -> result 0; opcode 1111 -> result 0.
//  - Assert reset during EXEC -> next cycle IDLE, busy=0, no rsp_valid ever for that op; next ADD correct.

Source files
------------

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_share_arbiter
//  Description : Round-robin sharing of one combinational ALU between two
//                valid/ready requesters. Operands are registered before the
//                ALU and the result is registered after it. One operation is
//                in flight at a time (IDLE -> EXEC -> RESP -> IDLE).
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    // requester 0
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [DATA_WIDTH-1:0]    req0_a,
    input  logic [DATA_WIDTH-1:0]    req0_b,
    input  logic [OPCODE_LENGTH-1:0] req0_op,
    // requester 1
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [DATA_WIDTH-1:0]    req1_a,
    input  logic [DATA_WIDTH-1:0]    req1_b,
    input  logic [OPCODE_LENGTH-1:0] req1_op,
    // responses
    output logic                     rsp0_valid,
    input  logic                     rsp0_ready,
    output logic [DATA_WIDTH-1:0]    rsp0_result,
    output logic                     rsp1_valid,
    input  logic                     rsp1_ready,
    output logic [DATA_WIDTH-1:0]    rsp1_result,
    // shared ALU
    output logic [DATA_WIDTH-1:0]    alu_srca,
    output logic [DATA_WIDTH-1:0]    alu_srcb,
    output logic [OPCODE_LENGTH-1:0] alu_op,
    input  logic [DATA_WIDTH-1:0]    alu_result,
    output logic                     busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                     r_state;
    logic [DATA_WIDTH-1:0]      r_srca;
    logic [DATA_WIDTH-1:0]      r_srcb;
    logic [OPCODE_LENGTH-1:0]   r_op;
    logic [DATA_WIDTH-1:0]      r_result;
    logic                       r_owner;
    logic                       r_last_grant;
    logic                       r_busy;
    logic                       r_rsp0_valid;
    logic                       r_rsp1_valid;

    logic                       w_grant;
    logic                       w_any_valid;
    logic                       w_owner_ready;

    // Sole valid requester wins; on contention the one not granted last wins.
    assign w_any_valid   = req0_valid | req1_valid;
    assign w_grant       = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
    assign req0_ready    = (r_state == IDLE) && req0_valid && !w_grant;
    assign req1_ready    = (r_state == IDLE) && req1_valid &&  w_grant;
    // Only the owning requester's rsp_ready can retire the response.
    assign w_owner_ready = r_owner ? rsp1_ready : rsp0_ready;

    assign alu_srca    = r_srca;
    assign alu_srcb    = r_srcb;
    assign alu_op      = r_op;
    assign rsp0_valid  = r_rsp0_valid;
    assign rsp1_valid  = r_rsp1_valid;
    assign rsp0_result = r_result;
    assign rsp1_result = r_result;
    assign busy        = r_busy;

    // Control FSM with registered operand, result, owner and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_srca       <= '0;
            r_srcb       <= '0;
            r_op         <= '0;
            r_result     <= '0;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_busy       <= 1'b0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_valid) begin
                        r_srca       <= w_grant ? req1_a  : req0_a;
                        r_srcb       <= w_grant ? req1_b  : req0_b;
                        r_op         <= w_grant ? req1_op : req0_op;
                        r_owner      <= w_grant;
                        r_last_grant <= w_grant;
                        r_busy       <= 1'b1;
                        r_state      <= EXEC;
                    end
                end
                EXEC: begin
                    r_result     <= alu_result;
                    r_rsp0_valid <= ~r_owner;
                    r_rsp1_valid <=  r_owner;
                    r_state      <= RESP;
                end
                RESP: begin
                    if (w_owner_ready) begin
                        r_rsp0_valid <= 1'b0;
                        r_rsp1_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_rsp0_valid <= 1'b0;
                    r_rsp1_valid <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_share_arbiter
//  Description : Directed self-checking bench for alu_share_arbiter with a
//                small behavioural ALU (ADD 0010, XOR 0011, EQ 1000, else 0).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp0_result, rsp1_result;
    logic [31:0] alu_srca, alu_srcb, alu_result;
    logic [3:0]  alu_op;
    logic        busy;

    int checks = 0;
    int passed = 0;

    alu_share_arbiter #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_op(alu_op),
        .alu_result(alu_result), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU attached to the shared port.
    always_comb begin
        alu_result = 32'd0;
        case (alu_op)
            4'b0010: alu_result = alu_srca + alu_srcb;
            4'b0011: alu_result = alu_srca ^ alu_srcb;
            4'b1000: alu_result = {31'd0, alu_srca == alu_srcb};
            default: alu_result = 32'd0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int side, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] op);
        if (side == 0) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
        end
    endtask

    // Single-requester operation with exact latency and handshake checks.
    task automatic run_op(input string tag, input int side, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] op, input logic [31:0] exp);
        set_req(side, 1'b1, a, b, op);
        #1;
        chk({tag, "_ready"}, side == 0 ? req0_ready : req1_ready, 32'd1);
        tick();
        if (side == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        #1;
        chk({tag, "_exec_srca"}, alu_srca, a);
        chk({tag, "_exec_op"}, {28'd0, alu_op}, {28'd0, op});
        chk({tag, "_exec_novalid"}, {31'd0, rsp0_valid | rsp1_valid}, 32'd0);
        tick();
        chk({tag, "_rsp_valid"}, side == 0 ? rsp0_valid : rsp1_valid, 32'd1);
        chk({tag, "_rsp_other"}, side == 0 ? rsp1_valid : rsp0_valid, 32'd0);
        chk({tag, "_result"}, side == 0 ? rsp0_result : rsp1_result, exp);
        if (side == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0;
        rsp0_ready = 0; rsp1_ready = 0;
        do_reset();

        // Reset state
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        chk("rst_srca", alu_srca, 32'd0);
        chk("rst_op", {28'd0, alu_op}, 32'd0);
        chk("rst_result", rsp0_result, 32'd0);
        chk("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);

        // First ADD from requester 0
        run_op("add0", 0, 32'd5, 32'd7, 4'b0010, 32'd12);

        // Contention after fresh reset: req0 first, then req1 XOR
        do_reset();
        set_req(0, 1'b1, 32'd3, 32'd4, 4'b0010);
        set_req(1, 1'b1, 32'hF0, 32'hFF, 4'b0011);
        #1;
        chk("cont_ready", {30'd0, req1_ready, req0_ready}, 32'd1);
        tick();
        req0_valid = 1'b0;
        #1;
        chk("cont_exec_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        tick();
        chk("cont_rsp0", {30'd0, rsp1_valid, rsp0_valid}, 32'd1);
        chk("cont_res0", rsp0_result, 32'd7);
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        chk("cont_ready1", {30'd0, req1_ready, req0_ready}, 32'd2);
        tick();
        req1_valid = 1'b0;
        tick();
        chk("cont_rsp1", {30'd0, rsp1_valid, rsp0_valid}, 32'd2);
        chk("cont_res1", rsp1_result, 32'h0F);
        rsp1_ready = 1'b1;
        tick();
        rsp1_ready = 1'b0;

        // Fairness: both valid continuously, last grant was 1 so 0 leads
        set_req(0, 1'b1, 32'd100, 32'd1, 4'b0010);
        set_req(1, 1'b1, 32'hAA, 32'h55, 4'b0011);
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            chk("fair_ready", {30'd0, req1_ready, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
            tick();
            tick();
            chk("fair_owner", {30'd0, rsp1_valid, rsp0_valid}, (i % 2 == 0) ? 32'd1 : 32'd2);
            chk("fair_result", (i % 2 == 0) ? rsp0_result : rsp1_result,
                (i % 2 == 0) ? 32'd101 : 32'hFF);
            tick();
        end
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;

        // Response back-pressure: hold for 4 cycles, foreign rsp_ready ignored
        set_req(0, 1'b1, 32'd20, 32'd22, 4'b0010);
        tick();
        req0_valid = 1'b0;
        tick();
        tick();
        set_req(1, 1'b1, 32'h12, 32'h12, 4'b0011);
        rsp1_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("stall_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd1);
            chk("stall_result", rsp0_result, 32'd42);
            chk("stall_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
            chk("stall_busy", {31'd0, busy}, 32'd1);
            tick();
        end
        rsp1_ready = 1'b0;
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        chk("stall_release", {31'd0, rsp0_valid}, 32'd0);
        run_op("stall_req1", 1, 32'h12, 32'h12, 4'b0011, 32'd0);

        // Equality and undefined opcodes
        run_op("eq_same", 0, 32'hDEADBEEF, 32'hDEADBEEF, 4'b1000, 32'd1);
        run_op("eq_diff", 0, 32'd1, 32'd2, 4'b1000, 32'd0);
        run_op("undef_op", 1, 32'd1, 32'd2, 4'b1111, 32'd0);

        // Reset during EXEC discards the operation
        set_req(0, 1'b1, 32'd1, 32'd1, 4'b0010);
        tick();
        req0_valid = 1'b0;
        #1;
        chk("mid_exec_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_srca", alu_srca, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("mid_rst_norsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
            tick();
        end
        run_op("post_rst_add", 0, 32'd9, 32'd8, 4'b0010, 32'd17);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
